key_scan: RTL and testbench
===========================

Name: key_scan

Overview:
- Input-side companion to the LED output drivers on the same board.
- Samples KEY_W active-low pushbuttons, synchronises and debounces each one independently.
- Emits single-cycle press/release event pulses plus a debounced level per key.
- Consumers are LED/display control logic running on sys_clk; one instance per board key bank.

Parameters:
KEY_W, 4, number of independent keys.
CNT_MAX, 20'd999_999, debounce window in cycles minus one (20 ms at 50 MHz).
LONG_MAX, 26'd49_999_999, hold time in cycles minus one for a long-press event (1 s at 50 MHz; used only with the optional feature).

Ports:
sys_clk  input  1  system clock; the only clock.
sys_rst  input  1  synchronous, active-high reset.
key_in  input  KEY_W  raw asynchronous button pins, active-low (0 = pressed).
key_level  output  KEY_W  debounced state, 1 = pressed.
key_press  output  KEY_W  one-cycle pulse per debounced press.
key_release  output  KEY_W  one-cycle pulse per debounced release.
key_long  output  KEY_W  one-cycle pulse per long hold; constant 0 without the optional feature.

Behaviour:
- Interface (already decided): one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Synchroniser: two flops per key, reset to 1 (released); key_sync is the second flop.
- Per-key FSM, keys fully independent: IDLE, PRESS_DB, DOWN, RELEASE_DB.
  - Each key has a debounce counter cnt, width matching CNT_MAX.
- IDLE: key_sync=0 -> PRESS_DB, cnt<=0.
- PRESS_DB:
  - key_sync=1 -> IDLE, cnt<=0 (bounce rejected, no event).
  - else if cnt<CNT_MAX -> cnt++.
  - else (cnt==CNT_MAX) -> DOWN, key_press pulse.
- DOWN: key_sync=1 -> RELEASE_DB, cnt<=0.
- RELEASE_DB:
  - key_sync=0 -> DOWN, cnt<=0 (no event).
  - else count as above; at cnt==CNT_MAX -> IDLE, key_release pulse.
- Latency:
  - key_press is high in the cycle after the edge on which key_sync has been sampled low on CNT_MAX+2 consecutive edges.
  - From the pin this is CNT_MAX+4 edges.
  - key_release uses the same timing with high samples.
- key_level = 1 in DOWN and RELEASE_DB, 0 in IDLE and PRESS_DB. It is registered and changes on the same edge as the press/release pulse.
- All outputs are registered. Pulses are exactly one cycle wide, with at most one press and one release per debounced cycle.
- Several keys may pulse in the same cycle; there is no arbitration.
- Bounce shorter than CNT_MAX+2 samples never produces an event. Any opposite sample restarts the window from 0.
- Reset, including mid-debounce or mid-hold:
  - Next edge gives state IDLE, cnt=0, synchronisers=1, all outputs 0.
  - No release pulse is generated.
  - A key held through reset is re-debounced and reports a fresh key_press.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - Each key has a hold counter, width matching LONG_MAX, cleared on entry to DOWN.
  - It increments while in DOWN or RELEASE_DB and saturates.
  - When it reaches LONG_MAX, key_long pulses once. No repeat until the key is released to IDLE and pressed again.
  - Cleared by reset.
- Undefined: hold counter not built; key_long tied to 0.

Decomposition:
- Package key_pkg holds:
  - typedef key_state_t: 2-bit enum IDLE=0, PRESS_DB=1, DOWN=2, RELEASE_DB=3.
  - Default constants KEY_CNT_MAX_DEF and KEY_LONG_MAX_DEF.
- Sub-module key_filter holds one key's synchroniser, FSM, counters and outputs.
- key_scan generates KEY_W instances of key_filter.

Test Plan (bench overrides CNT_MAX=9, LONG_MAX=49):
- Reset with key_in=4'b0000 held -> all outputs 0 during reset; after reset key_level=4'b1111 and key_press=4'b1111 pulse exactly 13 edges after reset deassert, 1 cycle wide.
- key_in[0] low for 8 cycles then high, repeated 5 times -> no key_press, key_level[0] stays 0.
- key_in[1] clean press for 30 cycles then release -> key_press[1] 1 cycle at edge 13, key_level[1]=1, key_release[1] 1 cycle 13 edges after release.
- key_in[2] pressed, then one 3-cycle high glitch inside DOWN -> no key_release, key_level[2] stays 1.
- sys_rst asserted 5 cycles into key_in[3]'s PRESS_DB -> no pulse; after reset, key still low gives key_press[3] at edge 13.
- With KEY_LONG_PRESS_EN, hold key_in[0] for 100 cycles -> key_long[0] single pulse 50 edges after key_press[0]; without the macro, key_long=0 throughout.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared types and constants for the key_scan pushbutton front end.
//   key_state_t      : per-key debounce FSM state (2-bit enum)
//   KEY_CNT_W        : width of the debounce window counter
//   KEY_LONG_W       : width of the long-press hold counter
//   KEY_CNT_MAX_DEF  : default debounce window, cycles minus one (20 ms @ 50 MHz)
//   KEY_LONG_MAX_DEF : default long-press hold, cycles minus one (1 s @ 50 MHz)
//   key_is_held()    : true in the states where the debounced level is "pressed"
// -----------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    DOWN       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  localparam int KEY_CNT_W  = 20;
  localparam int KEY_LONG_W = 26;

  localparam logic [KEY_CNT_W-1:0]  KEY_CNT_MAX_DEF  = 20'd999_999;
  localparam logic [KEY_LONG_W-1:0] KEY_LONG_MAX_DEF = 26'd49_999_999;

  localparam logic [KEY_CNT_W-1:0]  KEY_CNT_ZERO  = {KEY_CNT_W{1'b0}};
  localparam logic [KEY_CNT_W-1:0]  KEY_CNT_ONE   = {{(KEY_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [KEY_LONG_W-1:0] KEY_LONG_ZERO = {KEY_LONG_W{1'b0}};
  localparam logic [KEY_LONG_W-1:0] KEY_LONG_ONE  = {{(KEY_LONG_W-1){1'b0}}, 1'b1};

  // The debounced level reads "pressed" from DOWN until a release completes,
  // so RELEASE_DB still counts as held.
  function automatic logic key_is_held(input key_state_t s);
    logic held;
    case (s)
      DOWN:       held = 1'b1;
      RELEASE_DB: held = 1'b1;
      IDLE:       held = 1'b0;
      PRESS_DB:   held = 1'b0;
      default:    held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/key_filter.sv
// -----------------------------------------------------------------------------
// key_filter
// One pushbutton: two-flop synchroniser, debounce FSM with window counter,
// and registered level / press / release / long-press outputs.
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined;
// otherwise key_long is held at 0.
// Ports:
//   sys_clk     : system clock
//   sys_rst     : synchronous, active-high reset
//   key_raw     : raw asynchronous pin, active-low (0 = pressed)
//   key_level   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on a debounced press
//   key_release : one-cycle pulse on a debounced release
//   key_long    : one-cycle pulse after LONG_MAX+1 held cycles (optional)
// -----------------------------------------------------------------------------
module key_filter
  import key_pkg::*;
#(
  parameter logic [KEY_CNT_W-1:0]  CNT_MAX  = KEY_CNT_MAX_DEF,
  parameter logic [KEY_LONG_W-1:0] LONG_MAX = KEY_LONG_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  logic                 meta_q, meta_d;
  logic                 sync_q, sync_d;
  key_state_t           state_q, state_d;
  logic [KEY_CNT_W-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;

  // Synchroniser next-state: the raw pin ripples through two stages.
  always_comb begin
    meta_d = key_raw;
    sync_d = meta_q;
  end

  // Debounce FSM next-state and pulse decode; any opposite sample while
  // debouncing returns to the stable state and restarts the window.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = KEY_CNT_ZERO;
        if (!sync_q) begin
          state_d = PRESS_DB;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_DB: begin
        if (sync_q) begin
          state_d = IDLE;
          cnt_d   = KEY_CNT_ZERO;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + KEY_CNT_ONE;
        end else begin
          state_d = DOWN;
          cnt_d   = KEY_CNT_ZERO;
          press_d = 1'b1;
        end
      end
      DOWN: begin
        cnt_d = KEY_CNT_ZERO;
        if (sync_q) begin
          state_d = RELEASE_DB;
        end else begin
          state_d = DOWN;
        end
      end
      RELEASE_DB: begin
        if (!sync_q) begin
          state_d = DOWN;
          cnt_d   = KEY_CNT_ZERO;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + KEY_CNT_ONE;
        end else begin
          state_d   = IDLE;
          cnt_d     = KEY_CNT_ZERO;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = KEY_CNT_ZERO;
      end
    endcase
    // Level is registered from the next state, so it moves on the same edge
    // as the press/release pulse.
    level_d = key_is_held(state_d);
  end

`ifdef KEY_LONG_PRESS_EN
  logic [KEY_LONG_W-1:0] hold_q, hold_d;
  logic                  long_done_q, long_done_d;
  logic                  enter_down_s;

  // Hold counter: restarts on every entry to DOWN, saturates at LONG_MAX and
  // fires once; the done flag only clears once the key is back out of DOWN /
  // RELEASE_DB, so a release bounce cannot produce a second long pulse.
  always_comb begin
    hold_d       = hold_q;
    long_done_d  = long_done_q;
    long_d       = 1'b0;
    enter_down_s = (state_d == DOWN) && (state_q != DOWN);
    if (key_is_held(state_q)) begin
      if (hold_q < LONG_MAX) begin
        hold_d = hold_q + KEY_LONG_ONE;
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d      = KEY_LONG_ZERO;
      long_done_d = 1'b0;
    end
    if (enter_down_s) begin
      hold_d = KEY_LONG_ZERO;
    end else begin
      hold_d = hold_d;
    end
  end

  // Hold counter and done-flag registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_q      <= KEY_LONG_ZERO;
      long_done_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
    end
  end
`else
  // Long-press detection not built: the pulse source is constant low.
  always_comb begin
    long_d = 1'b0;
  end
`endif

  // State, counter, synchroniser and output registers; synchroniser resets
  // to "released" so a key held through reset is debounced afresh.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= KEY_CNT_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/key_scan.sv
// -----------------------------------------------------------------------------
// key_scan
// Bank of KEY_W independent debounced pushbuttons on sys_clk. Each key gets
// its own key_filter; keys never interact and may pulse in the same cycle.
// Optional feature macro: KEY_LONG_PRESS_EN (enables key_long pulses).
// Ports:
//   sys_clk     : system clock, the only clock
//   sys_rst     : synchronous, active-high reset
//   key_in      : raw active-low button pins (0 = pressed)
//   key_level   : debounced level per key, 1 = pressed
//   key_press   : one-cycle pulse per debounced press
//   key_release : one-cycle pulse per debounced release
//   key_long    : one-cycle pulse per long hold (0 without KEY_LONG_PRESS_EN)
// -----------------------------------------------------------------------------
module key_scan
  import key_pkg::*;
#(
  parameter int                    KEY_W    = 4,
  parameter logic [KEY_CNT_W-1:0]  CNT_MAX  = KEY_CNT_MAX_DEF,
  parameter logic [KEY_LONG_W-1:0] LONG_MAX = KEY_LONG_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  for (genvar k = 0; k < KEY_W; k++) begin : g_key
    key_filter #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_filter (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_raw     (key_in[k]),
      .key_level   (key_level[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k]),
      .key_long    (key_long[k])
    );
  end

endmodule

// File: tb/tb_key_scan.sv
// -----------------------------------------------------------------------------
// tb_key_scan
// Self-checking bench for key_scan with CNT_MAX=9, LONG_MAX=49. A reference
// model describes each key by its debounced level and the length of the
// current run of opposite synchronised samples; the level flips once that
// run reaches CNT_MAX+2. Long presses are judged by elapsed edges since the
// last entry into the held state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_scan;

  localparam int KW   = 4;
  localparam int CNT  = 9;
  localparam int LONG = 49;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [KW-1:0] key_in  = 4'b1111;
  logic [KW-1:0] key_level, key_press, key_release, key_long;

  key_scan #(
    .KEY_W    (KW),
    .CNT_MAX  (20'd9),
    .LONG_MAX (26'd49)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            p1 [KW];
  bit            p2 [KW];
  bit            lvl[KW];
  int            run[KW];
  int            entry_t[KW];
  bit            fired[KW];
  int            now = 0;
  logic [KW-1:0] m_level, m_press, m_release, m_long;

  task automatic model_reset();
    for (int k = 0; k < KW; k++) begin
      p1[k] = 1'b1; p2[k] = 1'b1; lvl[k] = 1'b0; run[k] = 0;
      entry_t[k] = 0; fired[k] = 1'b0;
    end
    m_level = '0; m_press = '0; m_release = '0; m_long = '0;
  endtask

  task automatic model_step();
    bit pressed;
    bit was_held;
    now++;
    if (sys_rst) begin
      model_reset();
    end else begin
      m_press = '0; m_release = '0; m_long = '0;
      for (int k = 0; k < KW; k++) begin
        pressed  = !p2[k];
        p2[k]    = p1[k];
        p1[k]    = key_in[k];
        was_held = lvl[k];
`ifdef KEY_LONG_PRESS_EN
        if (was_held && !fired[k] && (now - entry_t[k] == LONG + 1)) begin
          m_long[k] = 1'b1;
          fired[k]  = 1'b1;
        end
`endif
        if (pressed != lvl[k]) begin
          run[k]++;
          if (run[k] == CNT + 2) begin
            lvl[k] = pressed;
            run[k] = 0;
            if (pressed) begin
              m_press[k] = 1'b1;
              entry_t[k] = now;
              fired[k]   = 1'b0;
            end else begin
              m_release[k] = 1'b1;
            end
          end
        end else begin
          // A release bounce that settles back to pressed re-enters the hold.
          if (run[k] > 0 && lvl[k]) entry_t[k] = now;
          run[k] = 0;
        end
      end
      for (int k = 0; k < KW; k++) m_level[k] = lvl[k];
    end
  endtask

  // One clock: model advances at the edge, DUT sampled on the falling edge.
  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    check_eq("level",   {28'd0, key_level},   {28'd0, m_level});
    check_eq("press",   {28'd0, key_press},   {28'd0, m_press});
    check_eq("release", {28'd0, key_release}, {28'd0, m_release});
    check_eq("long",    {28'd0, key_long},    {28'd0, m_long});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int first_press, press_cnt, seen, tp, tl, long_cnt;
  int seg_left[KW];

  initial begin
    model_reset();
    @(negedge sys_clk);

    // Reset with all keys held low: outputs stay 0, then a fresh press.
    sys_rst = 1'b1; key_in = 4'b0000;
    ticks(3);
    check_eq("rst_level", {28'd0, key_level}, 32'd0);
    sys_rst = 1'b0;
    first_press = -1; press_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (key_press == 4'b1111) begin
        press_cnt++;
        if (first_press < 0) first_press = i;
      end
    end
    check_eq("rst_press_latency", first_press, 32'd13);
    check_eq("rst_press_width",   press_cnt,   32'd1);
    check_eq("rst_level_after",   {28'd0, key_level}, 32'd15);
    key_in = 4'b1111;
    ticks(20);

    // Key 0 bounces shorter than the window: never reported.
    seen = 0;
    for (int r = 0; r < 5; r++) begin
      key_in[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin tick(); if (key_press[0] || key_level[0]) seen++; end
      key_in[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin tick(); if (key_press[0] || key_level[0]) seen++; end
    end
    check_eq("bounce_no_press", seen, 32'd0);

    // Key 1 clean press/release.
    key_in[1] = 1'b0; tp = -1;
    for (int i = 1; i <= 30; i++) begin tick(); if (key_press[1] && tp < 0) tp = i; end
    check_eq("k1_press_edge", tp, 32'd13);
    key_in[1] = 1'b1; tp = -1;
    for (int i = 1; i <= 20; i++) begin tick(); if (key_release[1] && tp < 0) tp = i; end
    check_eq("k1_release_edge", tp, 32'd13);

    // Key 2: short high glitch while held does not release.
    key_in[2] = 1'b0; ticks(20);
    key_in[2] = 1'b1; ticks(3);
    key_in[2] = 1'b0; seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (key_release[2] || !key_level[2]) seen++; end
    check_eq("k2_glitch_no_release", seen, 32'd0);
    key_in[2] = 1'b1; ticks(20);

    // Key 3: reset mid-debounce, still held afterwards.
    key_in[3] = 1'b0; ticks(7);
    sys_rst = 1'b1; ticks(2);
    sys_rst = 1'b0; tp = -1; seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (key_press[3] && tp < 0) tp = i;
      if (key_release[3]) seen++;
    end
    check_eq("k3_rst_press_edge", tp, 32'd13);
    check_eq("k3_rst_no_release", seen, 32'd0);
    key_in[3] = 1'b1; ticks(20);

    // Key 0 long hold.
    key_in[0] = 1'b0; tp = -1; tl = -1; long_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (key_press[0] && tp < 0) tp = i;
      if (key_long[0]) begin long_cnt++; if (tl < 0) tl = i; end
    end
`ifdef KEY_LONG_PRESS_EN
    check_eq("long_delay", tl - tp, 32'd50);
    check_eq("long_count", long_cnt, 32'd1);
`else
    check_eq("long_count", long_cnt, 32'd0);
`endif
    key_in[0] = 1'b1; ticks(20);

    // Randomised segments, mostly near the debounce window, some long holds.
    for (int k = 0; k < KW; k++) seg_left[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < KW; k++) begin
        if (seg_left[k] == 0) begin
          key_in[k]   = ~key_in[k];
          seg_left[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 80)
                                                     : $urandom_range(1, 16);
        end
        seg_left[k]--;
      end
      sys_rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    sys_rst = 1'b0;
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
